// File: rtl/spi_pkg.sv
// Shared types and constants for the multi-chip-select SPI master.
package spi_pkg;

   localparam int SPI_MAX_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } spi_state_t;

   typedef struct packed {
      logic cpol;
      logic cpha;
      logic lsb_first;
   } spi_mode_t;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer for the SPI master: down-counter reloaded from the divider
// latched at transfer start, plus leading/trailing sclk edge strobes.
module spi_clk_gen #(
   parameter int DVSR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              run,
   input  logic              edge_en,
   input  logic [DVSR_W-1:0] dvsr,
   output logic              tick,
   output logic              lead_tick,
   output logic              trail_tick
);

   logic [DVSR_W-1:0] dvsr_q;
   logic [DVSR_W-1:0] cnt;
   logic              phase;

   // Reload on zero rather than wrapping, so dvsr=0 yields a tick every cycle.
   assign tick       = run && (cnt == '0);
   assign lead_tick  = tick && edge_en && !phase;
   assign trail_tick = tick && edge_en && phase;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dvsr_q <= '0;
         cnt    <= '0;
         phase  <= 1'b0;
      end else if (load) begin
         dvsr_q <= dvsr;
         cnt    <= dvsr;
         phase  <= 1'b0;
      end else if (run) begin
         if (cnt == '0) begin
            cnt <= dvsr_q;
         end else begin
            cnt <= cnt - DVSR_W'(1);
         end
         if (tick && edge_en) begin
            phase <= ~phase;
         end
      end
   end

endmodule

// File: rtl/spi_master_mc.sv
// SPI master with runtime mode/bit order, NUM_CS chip selects and a clock divider.
// Define SPI_MASTER_LOOPBACK_EN to route the registered mosi back as the internal miso.
module spi_master_mc
   import spi_pkg::*;
#(
   parameter int  WIDTH  = 8,
   parameter int  NUM_CS = 4,
   parameter int  DVSR_W = 16,
   localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              ready,
   input  logic [WIDTH-1:0]  din,
   input  logic [CS_W-1:0]   cs_sel,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsb_first,
   input  logic [DVSR_W-1:0] dvsr,
   output logic              sclk,
   output logic              mosi,
   output logic [NUM_CS-1:0] cs_n,
   input  logic              miso,
   output logic              rx_vld,
   output logic [WIDTH-1:0]  rx_dout,
   output spi_state_t        dbg_state
);

   localparam int ECNT_W = $clog2(2 * SPI_MAX_WIDTH + 1);
   localparam logic [ECNT_W-1:0] LAST_EDGE = ECNT_W'(2 * WIDTH);

   spi_state_t        state;
   spi_mode_t         mode;
   logic [WIDTH-1:0]  tx;
   logic [WIDTH-1:0]  rx;
   logic [ECNT_W-1:0] ecnt;
   logic [NUM_CS-1:0] cs_dec;
   logic              miso_int;
   logic              accept;
   logic              edge_en;
   logic              tick;
   logic              lead_tick;
   logic              trail_tick;

`ifdef SPI_MASTER_LOOPBACK_EN
   assign miso_int = mosi;
`else
   assign miso_int = miso;
`endif

   // Handshake: a transfer is accepted on any clk edge where start && ready;
   // ready is high only in IDLE and start is ignored otherwise.
   assign accept    = (state == IDLE) && start;
   assign edge_en   = (state == SETUP) || ((state == SHIFT) && (ecnt != LAST_EDGE));
   assign dbg_state = state;

   always_comb begin
      cs_dec = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (int'(cs_sel) == i) begin
            cs_dec[i] = 1'b0;
         end
      end
   end

   function automatic logic out_bit(input logic [WIDTH-1:0] v, input logic lsb);
      return lsb ? v[0] : v[WIDTH-1];
   endfunction

   function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v, input logic lsb);
      return lsb ? (v >> 1) : (v << 1);
   endfunction

   spi_clk_gen #(
      .DVSR_W(DVSR_W)
   ) u_clk_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept),
      .run       (state != IDLE),
      .edge_en   (edge_en),
      .dvsr      (dvsr),
      .tick      (tick),
      .lead_tick (lead_tick),
      .trail_tick(trail_tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         mode    <= '0;
         tx      <= '0;
         rx      <= '0;
         rx_dout <= '0;
         rx_vld  <= 1'b0;
         ready   <= 1'b1;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
         cs_n    <= '1;
         ecnt    <= '0;
      end else begin
         rx_vld <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= SETUP;
                  ready <= 1'b0;
                  mode  <= '{cpol: cpol, cpha: cpha, lsb_first: lsb_first};
                  cs_n  <= cs_dec;
                  sclk  <= cpol;
                  rx    <= '0;
                  ecnt  <= '0;
                  // CPHA=0 needs the first bit on the wire before the first edge.
                  if (!cpha) begin
                     mosi <= out_bit(din, lsb_first);
                     tx   <= shift_out(din, lsb_first);
                  end else begin
                     mosi <= 1'b0;
                     tx   <= din;
                  end
               end
            end
            SETUP: begin
               if (tick) begin
                  state <= SHIFT;
                  sclk  <= ~sclk;
                  ecnt  <= ECNT_W'(1);
               end
            end
            SHIFT: begin
               if (tick) begin
                  if (ecnt == LAST_EDGE) begin
                     state <= HOLD;
                  end else begin
                     sclk <= ~sclk;
                     ecnt <= ecnt + ECNT_W'(1);
                  end
               end
            end
            HOLD: begin
               if (tick) begin
                  state   <= IDLE;
                  ready   <= 1'b1;
                  rx_vld  <= 1'b1;
                  rx_dout <= rx;
                  cs_n    <= '1;
                  sclk    <= mode.cpol;
               end
            end
            default: state <= IDLE;
         endcase

         if ((lead_tick && mode.cpha) || (trail_tick && !mode.cpha)) begin
            mosi <= out_bit(tx, mode.lsb_first);
            tx   <= shift_out(tx, mode.lsb_first);
         end
         if ((lead_tick && !mode.cpha) || (trail_tick && mode.cpha)) begin
            rx <= mode.lsb_first ? {miso_int, rx[WIDTH-1:1]} : {rx[WIDTH-2:0], miso_int};
         end
      end
   end

endmodule

// File: doc/spi_master_mc.md
SPI_MASTER_MC -- requirements
Module: spi_master_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per word, legal range 2..32.
REQ-002 SHALL have parameter NUM_CS, default 4: number of chip selects, legal range 1..8.
REQ-003 SHALL have parameter DVSR_W, default 16: width of the clock-divider input.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: transfer request, accepted when start && ready.
REQ-007 SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-008 SHALL have port din, input, WIDTH bits: transmit word.
REQ-009 SHALL have port cs_sel, input, $clog2(NUM_CS) bits (minimum 1): selects the target slave.
REQ-010 SHALL have ports cpol and cpha, inputs, 1 bit each: runtime SPI mode.
REQ-011 SHALL have port lsb_first, input, 1 bit: bit order, 0 = MSB first.
REQ-012 SHALL have port dvsr, input, DVSR_W bits: half-period of sclk = dvsr+1 clk cycles.
REQ-013 SHALL have ports sclk, mosi and cs_n, outputs of 1, 1 and NUM_CS bits: the SPI bus, cs_n active-low.
REQ-014 SHALL have port miso, input, 1 bit.
REQ-015 SHALL have ports rx_vld, output, 1 bit, and rx_dout, output, WIDTH bits: received word and its one-cycle valid strobe.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, SHIFT and HOLD, with transitions IDLE->SETUP on accept, SETUP->SHIFT after one half-period, SHIFT->HOLD after 2*WIDTH half-periods, and HOLD->IDLE after one half-period.
REQ-017 SHALL latch din, cs_sel, cpol, cpha, lsb_first and dvsr on accept; input changes during a transfer SHALL have no effect.
REQ-018 SHALL drive cs_n[cs_sel] low from the cycle after accept until HOLD exits; if cs_sel >= NUM_CS, the transfer SHALL run with all cs_n high.
REQ-019 SHALL keep sclk equal to the registered cpol in IDLE, SETUP and HOLD, and toggle it at each half-period boundary in SHIFT.
REQ-020 With CPHA=0, SHALL present the first mosi bit at SETUP entry, sample miso on leading edges and update mosi on trailing edges.
REQ-021 With CPHA=1, SHALL update mosi on leading edges and sample miso on trailing edges.
REQ-022 SHALL fill rx_dout in the same bit order as transmit, so that loopback reproduces din exactly.
REQ-023 SHALL pulse rx_vld for exactly one cycle, on the cycle entering IDLE.
REQ-024 SHALL hold rx_dout stable until the next rx_vld.
REQ-025 SHALL have a latency from the accept cycle to rx_vld of exactly (dvsr+1)*(2*WIDTH+2)+1 cycles.
REQ-026 SHALL assert ready in the same cycle as rx_vld; a start in that cycle SHALL be accepted, giving back-to-back transfers with cs_n deasserted for at least one cycle between them.
REQ-027 SHALL treat dvsr=0 as legal (half-period of 1 cycle); the divider counter SHALL never wrap mid-half-period.

Reset
REQ-028 On rst_n low at a clk edge, SHALL set state=IDLE, ready=1, sclk=0, mosi=0, cs_n=all ones, rx_vld=0, rx_dout=0 and latched mode=0.
REQ-029 A reset during any state SHALL abort the transfer, with no rx_vld pulse.

Configuration
REQ-030 SHALL support the macro SPI_MASTER_LOOPBACK_EN: when defined, the internal miso SHALL be the registered mosi and the miso port SHALL be ignored; when undefined, the miso port SHALL be used and no loopback logic SHALL exist.

Structure
REQ-031 Package spi_pkg SHALL hold the FSM state enum, a spi_mode_t struct {cpol, cpha, lsb_first} and the constant SPI_MAX_WIDTH=32.
REQ-032 Sub-module spi_clk_gen SHALL own the half-period down-counter and emit lead_tick and trail_tick pulses; spi_master_mc SHALL own the FSM and the shift registers.

Verification
REQ-033 Scenario: WIDTH=8, loopback enabled, mode 3, dvsr=31, din=0x95 -> rx_dout=0x95, rx_vld 577 cycles after accept, sclk idles high.
REQ-034 Scenario: all four modes x lsb_first, external miso driven by a slave model returning 0xA5 -> rx_dout=0xA5 in every case, and mosi matches the model's captured byte.
REQ-035 Scenario: dvsr=0, two back-to-back starts with din=0x3C then 0xC3 -> two rx_vld pulses 19 cycles apart, cs_n high for at least 1 cycle between transfers.
REQ-036 Scenario: cs_sel=2 with NUM_CS=4 -> only cs_n[2] asserted; cs_sel=5 with NUM_CS=4 -> cs_n stays 4'hF, rx_vld still pulses.
REQ-037 Scenario: rst_n low mid-SHIFT -> next cycle cs_n all high, sclk=0, ready=1, and no rx_vld.
REQ-038 Scenario: din, cpol and dvsr changed during SHIFT -> current transfer unaffected, and the new values are used only on the next accept.
